pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage 8-bit pipeline: generates enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus operand-forwarding selects for EX.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a timeout.
- Keeps a saturating stall-cycle counter for debug.
- Sits beside the pipeline registers; every pipeline register's enable and flush come from this block.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT before memError is set (1..255).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- idRs1, idRs2  input  3  source register numbers of the instruction in ID
- idUsesRs1, idUsesRs2  input  1  the ID instruction reads rs1/rs2
- exRs1, exRs2  input  3  source register numbers held in ID/EX
- exDest  input  3  destination register held in ID/EX
- exRegWrite, exLoad  input  1  ID/EX writes a register; ID/EX instruction is a load (regWriteDataSel = memory)
- branchTaken  input  1  branch resolved taken in EX
- memDest  input  3  EX/MEM destination
- memRegWrite  input  1  EX/MEM writes a register
- memReq  input  1  EX/MEM instruction accesses data memory this cycle
- memReady  input  1  data memory completes the access this cycle
- wbDest  input  3  MEM/WB destination
- wbRegWrite  input  1  MEM/WB writes a register
- pcEn, ifidEn, idexEn, exmemEn, memwbEn  output  1  pipeline register load enables
- ifidFlush, idexFlush, memwbFlush  output  1  load a bubble (all controls 0)
- forwardA, forwardB  output  2  00 = register file, 01 = EX/MEM aluResult, 10 = MEM/WB data
- memError  output  1  sticky memory-timeout flag
- stallCount  output  CNT_W  saturating count of stall cycles

Behaviour:
- Register 0 is hardwired zero. A destination of 0 never creates a hazard and never forwards.
- State machine states: RUN, MEM_WAIT.
- Enables, flushes and forwards are combinational from state and inputs. State, wait counter, memError and stallCount are registered.
- Reset (rst = 0 at a clk edge):
  - State = RUN, wait counter = 0, memError = 0, stallCount = 0.
  - Combinational outputs follow RUN rules.
  - Reset mid-MEM_WAIT abandons the wait immediately.
- RUN defaults: all enables 1, all flushes 0.
- Priority, highest first: memory wait, then branch, then load-use.
- Memory wait:
  - Condition: memReq = 1 and memReady = 0 in RUN.
  - Outputs: pcEn = ifidEn = idexEn = exmemEn = 0, memwbFlush = 1.
  - Next state = MEM_WAIT, wait counter = 1.
- MEM_WAIT:
  - Same frozen outputs while memReady = 0; the wait counter increments each cycle.
  - memReady = 1: all enables 1, memwbFlush = 0 (result advances), next state = RUN, counter cleared.
  - Branch and load-use are not evaluated in MEM_WAIT; they are re-evaluated in RUN on the next cycle.
  - Counter reaching MEM_TIMEOUT with memReady still 0: set memError = 1 and treat the access as complete (release as if memReady = 1).
  - memError clears only on reset.
- Branch:
  - Condition: branchTaken = 1 in RUN with no memory wait.
  - Outputs: ifidFlush = 1, idexFlush = 1, pcEn = 1. Squashes two instructions; zero stall cycles.
  - Suppresses load-use evaluation in the same cycle.
- Load-use:
  - Condition: exLoad & exRegWrite & (exDest != 0) & ((idUsesRs1 & idRs1 == exDest) | (idUsesRs2 & idRs2 == exDest)).
  - Outputs: pcEn = 0, ifidEn = 0, idexFlush = 1. Exactly one bubble; the hazard then clears because the load has moved to MEM.
- Forwarding, per operand (shown for A, using exRs1; B is identical with exRs2):
  - 01 if memRegWrite & memDest != 0 & memDest == exRs1.
  - Else 10 if wbRegWrite & wbDest != 0 & wbDest == exRs1.
  - Else 00. EX/MEM wins over MEM/WB.
  - Forwards are held stable during MEM_WAIT.
- stallCount:
  - Increments by 1 on every cycle where pcEn = 0.
  - Saturates at 2^CNT_W - 1; no wrap.

Decomposition:
- Shared package: state encoding (RUN = 0, MEM_WAIT = 1), forward-select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB), register-number width 3, ZERO_REG = 0.
- One sub-module, forwarding_unit: purely combinational and instantiated twice (operands A and B).
- State machine, priority logic and counters stay in the top module.

Test Plan:
- Reset: rst = 0 for 2 cycles with random inputs → all enables 1, flushes 0, memError 0, stallCount 0, forwardA/B 00 once inputs are quiet.
- Load-use: exLoad = 1, exRegWrite = 1, exDest = 3, idUsesRs2 = 1, idRs2 = 3 → one cycle with pcEn = 0, ifidEn = 0, idexFlush = 1, then stallCount = 1. Repeat with exDest = 0 → no stall.
- Branch priority: branchTaken = 1 plus the load-use condition in the same cycle → ifidFlush = idexFlush = 1, pcEn = 1, stallCount unchanged.
- Memory wait: memReq = 1, memReady low for 3 cycles then high → 3 frozen cycles with memwbFlush = 1, release on the 4th, stallCount = 3, memError = 0.
- Timeout: MEM_TIMEOUT = 4, memReady never asserted → memError = 1 after 4 MEM_WAIT cycles, return to RUN. memError stays 1 until rst = 0.
- Forwarding: memDest = wbDest = 5, both regWrite = 1, exRs1 = 5, exRs2 = 0 → forwardA = 01, forwardB = 00. Drop memRegWrite → forwardA = 10.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding units.
package pipeline_hazard_controller_pkg;

    localparam int REG_W = 3;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrlStateT;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwdSelT;

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// Operand-forwarding select for one EX source operand; the younger EX/MEM result wins over MEM/WB.
module forwarding_unit
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [REG_W-1:0] exRs,
    input  logic [REG_W-1:0] memDest,
    input  logic             memRegWrite,
    input  logic [REG_W-1:0] wbDest,
    input  logic             wbRegWrite,
    output fwdSelT           fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (memRegWrite && (memDest != ZERO_REG) && (memDest == exRs)) begin
            fwdSel = FWD_EXMEM;
        end else if (wbRegWrite && (wbDest != ZERO_REG) && (wbDest == exRs)) begin
            fwdSel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Enables, flushes and forwarding selects for the 5-stage pipeline, with memory-wait
// timeout detection and a saturating stall-cycle counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic [REG_W-1:0] exRs1,
    input  logic [REG_W-1:0] exRs2,
    input  logic [REG_W-1:0] exDest,
    input  logic             exRegWrite,
    input  logic             exLoad,
    input  logic             branchTaken,
    input  logic [REG_W-1:0] memDest,
    input  logic             memRegWrite,
    input  logic             memReq,
    input  logic             memReady,
    input  logic [REG_W-1:0] wbDest,
    input  logic             wbRegWrite,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             idexEn,
    output logic             exmemEn,
    output logic             memwbEn,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             memwbFlush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             memError,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ctrlStateT  state;
    logic [7:0] waitCnt;
    fwdSelT     liveA, liveB, heldA, heldB;
    logic       inWait, loadUse, timeoutHit;

    forwarding_unit fwdUnitA (
        .exRs        (exRs1),
        .memDest     (memDest),
        .memRegWrite (memRegWrite),
        .wbDest      (wbDest),
        .wbRegWrite  (wbRegWrite),
        .fwdSel      (liveA)
    );

    forwarding_unit fwdUnitB (
        .exRs        (exRs2),
        .memDest     (memDest),
        .memRegWrite (memRegWrite),
        .wbDest      (wbDest),
        .wbRegWrite  (wbRegWrite),
        .fwdSel      (liveB)
    );

    // While reset is asserted the outputs behave as if the controller were in RUN.
    assign inWait     = (state == MEM_WAIT) && rst;
    assign timeoutHit = inWait && !memReady && (waitCnt >= WAIT_LIMIT);
    assign loadUse    = exLoad && exRegWrite && (exDest != ZERO_REG) &&
                        ((idUsesRs1 && (idRs1 == exDest)) || (idUsesRs2 && (idRs2 == exDest)));

    // EX operands are frozen during a memory wait, so keep the selects chosen when it began.
    assign forwardA = inWait ? heldA : liveA;
    assign forwardB = inWait ? heldB : liveB;

    always_comb begin
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        memwbEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        if (inWait) begin
            if (!memReady && !timeoutHit) begin
                pcEn       = 1'b0;
                ifidEn     = 1'b0;
                idexEn     = 1'b0;
                exmemEn    = 1'b0;
                memwbFlush = 1'b1;
            end
        end else if (memReq && !memReady) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            memwbFlush = 1'b1;
        end else if (branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (loadUse) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            waitCnt    <= '0;
            memError   <= 1'b0;
            stallCount <= '0;
            heldA      <= FWD_RF;
            heldB      <= FWD_RF;
        end else begin
            if (!pcEn && (stallCount != CNT_MAX)) begin
                stallCount <= stallCount + CNT_ONE;
            end
            if (state == RUN) begin
                heldA <= liveA;
                heldB <= liveB;
            end
            case (state)
                RUN: begin
                    if (memReq && !memReady) begin
                        state   <= MEM_WAIT;
                        waitCnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (memReady || timeoutHit) begin
                        state   <= RUN;
                        waitCnt <= '0;
                        if (timeoutHit) begin
                            memError <= 1'b1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: table-driven single-cycle vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 4;
    localparam logic [TB_CNT_W-1:0] TB_CNT_MAX = '1;

    localparam logic [7:0] C_IDLE   = 8'hF8;
    localparam logic [7:0] C_LDUSE  = 8'h3A;
    localparam logic [7:0] C_BRANCH = 8'hFE;
    localparam logic [7:0] C_FROZEN = 8'h09;

    typedef struct packed {
        logic [2:0] idRs1;
        logic [2:0] idRs2;
        logic       idUsesRs1;
        logic       idUsesRs2;
        logic [2:0] exRs1;
        logic [2:0] exRs2;
        logic [2:0] exDest;
        logic       exRegWrite;
        logic       exLoad;
        logic       branchTaken;
        logic [2:0] memDest;
        logic       memRegWrite;
        logic       memReq;
        logic       memReady;
        logic [2:0] wbDest;
        logic       wbRegWrite;
    } stimT;

    typedef struct packed {
        logic [7:0]          ctrl;
        logic [1:0]          fwdA;
        logic [1:0]          fwdB;
        logic                memError;
        logic [TB_CNT_W-1:0] stallCount;
    } expT;

    typedef struct packed {
        stimT       s;
        logic [7:0] ctrl;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } vecT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] idRs1, idRs2, exRs1, exRs2, exDest, memDest, wbDest;
    logic idUsesRs1, idUsesRs2, exRegWrite, exLoad, branchTaken;
    logic memRegWrite, memReq, memReady, wbRegWrite;
    logic pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, memwbFlush;
    logic [1:0] forwardA, forwardB;
    logic memError;
    logic [TB_CNT_W-1:0] stallCount;

    int checks = 0;
    int errors = 0;
    logic [TB_CNT_W-1:0] expStall = '0;
    logic expErr = 1'b0;
    expT sbQ[$];
    vecT tbl[$];

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .exRs1       (exRs1),
        .exRs2       (exRs2),
        .exDest      (exDest),
        .exRegWrite  (exRegWrite),
        .exLoad      (exLoad),
        .branchTaken (branchTaken),
        .memDest     (memDest),
        .memRegWrite (memRegWrite),
        .memReq      (memReq),
        .memReady    (memReady),
        .wbDest      (wbDest),
        .wbRegWrite  (wbRegWrite),
        .pcEn        (pcEn),
        .ifidEn      (ifidEn),
        .idexEn      (idexEn),
        .exmemEn     (exmemEn),
        .memwbEn     (memwbEn),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .memwbFlush  (memwbFlush),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .memError    (memError),
        .stallCount  (stallCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveStim(input stimT s);
        idRs1       = s.idRs1;
        idRs2       = s.idRs2;
        idUsesRs1   = s.idUsesRs1;
        idUsesRs2   = s.idUsesRs2;
        exRs1       = s.exRs1;
        exRs2       = s.exRs2;
        exDest      = s.exDest;
        exRegWrite  = s.exRegWrite;
        exLoad      = s.exLoad;
        branchTaken = s.branchTaken;
        memDest     = s.memDest;
        memRegWrite = s.memRegWrite;
        memReq      = s.memReq;
        memReady    = s.memReady;
        wbDest      = s.wbDest;
        wbRegWrite  = s.wbRegWrite;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be during that cycle.
    task automatic applyStimulus(input stimT s, input logic [7:0] ctrl,
                                 input logic [1:0] fa, input logic [1:0] fb);
        expT e;
        @(negedge clk);
        driveStim(s);
        e.ctrl       = ctrl;
        e.fwdA       = fa;
        e.fwdB       = fb;
        e.memError   = expErr;
        e.stallCount = expStall;
        sbQ.push_back(e);
        if (!ctrl[7] && (expStall != TB_CNT_MAX)) begin
            expStall = expStall + 1'b1;
        end
    endtask

    task automatic checkOutput();
        expT e;
        #2;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbQ.pop_front();
        check("ctrl", {8'h00, pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, memwbFlush},
              {8'h00, e.ctrl});
        check("forwardA", {14'h0, forwardA}, {14'h0, e.fwdA});
        check("forwardB", {14'h0, forwardB}, {14'h0, e.fwdB});
        check("memError", {15'h0, memError}, {15'h0, e.memError});
        check("stallCount", {{(16-TB_CNT_W){1'b0}}, stallCount}, {{(16-TB_CNT_W){1'b0}}, e.stallCount});
    endtask

    task automatic step(input stimT s, input logic [7:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        applyStimulus(s, ctrl, fa, fb);
        checkOutput();
    endtask

    task automatic doReset();
        logic [31:0] rnd;
        stimT r;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rnd = $urandom();
            r = rnd[$bits(stimT)-1:0];
            driveStim(r);
        end
        @(negedge clk);
        driveStim('0);
        rst = 1'b1;
        expStall = '0;
        expErr = 1'b0;
    endtask

    task automatic addVec(input stimT s, input logic [7:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        vecT v;
        v.s = s;
        v.ctrl = ctrl;
        v.fwdA = fa;
        v.fwdB = fb;
        tbl.push_back(v);
    endtask

    initial begin
        stimT s;
        driveStim('0);
        doReset();

        s = '0;                                                             addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s = '0; s.exLoad = 1; s.exRegWrite = 1; s.exDest = 3;
        s.idUsesRs2 = 1; s.idRs2 = 3;                                       addVec(s, C_LDUSE, FWD_RF, FWD_RF);
        s = '0;                                                             addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s = '0; s.exLoad = 1; s.exRegWrite = 1; s.exDest = 0;
        s.idUsesRs2 = 1; s.idRs2 = 0;                                       addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s = '0; s.exLoad = 1; s.exRegWrite = 1; s.exDest = 6;
        s.idUsesRs1 = 1; s.idRs1 = 6;                                       addVec(s, C_LDUSE, FWD_RF, FWD_RF);
        s.idUsesRs1 = 0;                                                    addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s.idUsesRs1 = 1; s.exRegWrite = 0;                                  addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s.exRegWrite = 1; s.branchTaken = 1;                                addVec(s, C_BRANCH, FWD_RF, FWD_RF);
        s = '0; s.memDest = 5; s.wbDest = 5; s.memRegWrite = 1;
        s.wbRegWrite = 1; s.exRs1 = 5; s.exRs2 = 0;                         addVec(s, C_IDLE, FWD_EXMEM, FWD_RF);
        s.memRegWrite = 0;                                                  addVec(s, C_IDLE, FWD_MEMWB, FWD_RF);
        s.memRegWrite = 1; s.memDest = 2; s.exRs2 = 2;                      addVec(s, C_IDLE, FWD_MEMWB, FWD_EXMEM);
        s = '0; s.memRegWrite = 1; s.wbRegWrite = 1;                        addVec(s, C_IDLE, FWD_RF, FWD_RF);
        s = '0; s.memDest = 4; s.wbDest = 4; s.memRegWrite = 1;
        s.wbRegWrite = 1; s.exRs1 = 4; s.exRs2 = 4;                         addVec(s, C_IDLE, FWD_EXMEM, FWD_EXMEM);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s, tbl[i].ctrl, tbl[i].fwdA, tbl[i].fwdB);
            checkOutput();
        end

        // Memory wait released by memReady after three frozen cycles; forwards stay held.
        s = '0; s.memReq = 1; s.memDest = 5; s.memRegWrite = 1; s.exRs1 = 5;
        step(s, C_FROZEN, FWD_EXMEM, FWD_RF);
        s.memRegWrite = 0;
        step(s, C_FROZEN, FWD_EXMEM, FWD_RF);
        s.branchTaken = 1;
        step(s, C_FROZEN, FWD_EXMEM, FWD_RF);
        s.memReady = 1;
        step(s, C_IDLE, FWD_EXMEM, FWD_RF);
        step('0, C_IDLE, FWD_RF, FWD_RF);

        // Timeout: memReady never comes, release happens on the fifth cycle.
        s = '0; s.memReq = 1;
        repeat (TB_TIMEOUT) step(s, C_FROZEN, FWD_RF, FWD_RF);
        step(s, C_IDLE, FWD_RF, FWD_RF);
        expErr = 1'b1;
        step('0, C_IDLE, FWD_RF, FWD_RF);
        step('0, C_IDLE, FWD_RF, FWD_RF);

        // Continuous load-use stall drives the counter into saturation.
        s = '0; s.exLoad = 1; s.exRegWrite = 1; s.exDest = 7; s.idUsesRs1 = 1; s.idRs1 = 7;
        repeat (8) step(s, C_LDUSE, FWD_RF, FWD_RF);
        step('0, C_IDLE, FWD_RF, FWD_RF);

        // Reset in the middle of a wait abandons it and clears the sticky error.
        s = '0; s.memReq = 1;
        step(s, C_FROZEN, FWD_RF, FWD_RF);
        step(s, C_FROZEN, FWD_RF, FWD_RF);
        doReset();
        step('0, C_IDLE, FWD_RF, FWD_RF);
        step('0, C_IDLE, FWD_RF, FWD_RF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
